// File: rtl/jpeg_pkg.sv
// Shared constants and FSM encoding for the JPEG bit packer.
// JPEG_BYTE_STUFF_EN adds the StStuff state (0x00 after every emitted 0xFF).
package jpeg_pkg;

   localparam int unsigned MAX_LEN    = 20;
   localparam int unsigned BUF_W      = 32;
   localparam logic [7:0]  STUFF_BYTE = 8'h00;
   localparam logic        PAD_BIT    = 1'b1;

   typedef enum logic [2:0] {
      StRun,
`ifdef JPEG_BYTE_STUFF_EN
      StStuff,
`endif
      StPad,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/jpeg_bit_packer_if.sv
// Codeword-in / byte-out handshake bundle of the JPEG bit packer.
interface jpeg_bit_packer_if;
   import jpeg_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [4:0]         in_len;
   logic [MAX_LEN-1:0] in_code;
   logic               in_flush;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_byte;
   logic               done;

   modport master (
      output in_valid, in_len, in_code, in_flush, out_ready,
      input  in_ready, out_valid, out_byte, done
   );

   modport slave (
      input  in_valid, in_len, in_code, in_flush, out_ready,
      output in_ready, out_valid, out_byte, done
   );

endinterface

// File: rtl/bit_packer_out_reg.sv
// One-entry output byte register with valid/ready handshake.
// With JPEG_BYTE_STUFF_EN a loaded 0xFF arms a pending 0x00 that is sent next.
module bit_packer_out_reg
   import jpeg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_byte,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_byte,
   output logic       stuff_pending,
   output logic       free
);

   logic       valid_q;
   logic [7:0] byte_q;

   assign free      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_byte  = byte_q;

`ifdef JPEG_BYTE_STUFF_EN
   logic stuff_q;

   assign stuff_pending = stuff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         byte_q  <= 8'h00;
         stuff_q <= 1'b0;
      end else if (free) begin
         if (stuff_q) begin
            valid_q <= 1'b1;
            byte_q  <= STUFF_BYTE;
            stuff_q <= 1'b0;
         end else if (load) begin
            valid_q <= 1'b1;
            byte_q  <= load_byte;
            stuff_q <= (load_byte == 8'hFF);
         end else begin
            valid_q <= 1'b0;
         end
      end
   end
`else
   assign stuff_pending = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         byte_q  <= 8'h00;
      end else if (free) begin
         valid_q <= load;
         if (load) begin
            byte_q <= load_byte;
         end
      end
   end
`endif

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into bytes, pads on flush.
// JPEG_BYTE_STUFF_EN enables 0xFF -> 0xFF 0x00 stuffing.
module jpeg_bit_packer
   import jpeg_pkg::*;
(
   input logic              clk,
   input logic              rst,
   jpeg_bit_packer_if.slave bus
);

   state_e             state_q;
   logic [BUF_W-1:0]   acc_q;
   logic [BUF_W-1:0]   acc_pop;
   logic [BUF_W-1:0]   code_word;
   logic [5:0]         fill_q;
   logic [5:0]         fill_pop;
   logic [5:0]         shift;
   logic [MAX_LEN-1:0] code_mask;
   logic               done_q;
   logic               in_run;
   logic               accepting;
   logic               pop;
   logic               out_free;
   logic               stuff_pending;

`ifdef JPEG_BYTE_STUFF_EN
   assign in_run = (state_q == StRun) || (state_q == StStuff);
`else
   assign in_run = (state_q == StRun);
`endif

   // Readiness ignores in_len so the upstream encoder never needs to look ahead.
   assign bus.in_ready = in_run && (fill_q <= 6'(BUF_W - MAX_LEN));
   assign accepting    = bus.in_valid && bus.in_ready;
   assign pop          = (fill_q >= 6'd8) && out_free && !stuff_pending;
   assign bus.done     = done_q;

   always_comb begin
      acc_pop   = pop ? (acc_q << 8) : acc_q;
      fill_pop  = pop ? (fill_q - 6'd8) : fill_q;
      code_mask = (MAX_LEN'(1) << bus.in_len) - MAX_LEN'(1);
      shift     = 6'(BUF_W) - fill_pop - {1'b0, bus.in_len};
      code_word = {{(BUF_W - MAX_LEN){1'b0}}, bus.in_code & code_mask} << shift;
   end

   bit_packer_out_reg u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .load          (pop),
      .load_byte     (acc_q[BUF_W-1 -: 8]),
      .out_ready     (bus.out_ready),
      .out_valid     (bus.out_valid),
      .out_byte      (bus.out_byte),
      .stuff_pending (stuff_pending),
      .free          (out_free)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         acc_q   <= '0;
         fill_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         acc_q  <= accepting ? (acc_pop | code_word) : acc_pop;
         fill_q <= accepting ? (fill_pop + {1'b0, bus.in_len}) : fill_pop;
         unique case (state_q)
            StRun: begin
               if (accepting && bus.in_flush) begin
                  state_q <= StDrain;
`ifdef JPEG_BYTE_STUFF_EN
               end else if (pop && (acc_q[BUF_W-1 -: 8] == 8'hFF)) begin
                  state_q <= StStuff;
`endif
               end
            end
`ifdef JPEG_BYTE_STUFF_EN
            StStuff: begin
               if (accepting && bus.in_flush) begin
                  state_q <= StDrain;
               end else if (out_free) begin
                  state_q <= StRun;
               end
            end
`endif
            StDrain: begin
               // Whole bytes pop via the defaults; finish once the output side is idle.
               if (fill_q < 6'd8) begin
                  if (fill_q != '0) begin
                     state_q <= StPad;
                  end else if (out_free && !stuff_pending) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StPad: begin
               acc_q[BUF_W-1 -: 8] <= acc_q[BUF_W-1 -: 8] | ({8{PAD_BIT}} >> fill_q[2:0]);
               fill_q              <= 6'd8;
               state_q             <= StDrain;
            end
            StDone: begin
               acc_q   <= '0;
               fill_q  <= '0;
               state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst)
                    bus.in_valid |-> (bus.in_len <= 5'(MAX_LEN)));

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: directed table, corner sequences, random vs model.
module tb_jpeg_bit_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jpeg_bit_packer_if bus ();

   jpeg_bit_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks   = 0;
   int          errors   = 0;
   int unsigned cyc      = 0;
   int          done_cnt = 0;
   int unsigned done_cyc = 0;
   int unsigned acc_cyc  = 0;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   bit          mq[$];
   bit          rand_rdy = 1'b0;
   logic        hold_q   = 1'b0;
   logic [7:0]  hold_byte = 8'h00;

   typedef struct {
      logic [4:0]  l0;
      logic [19:0] c0;
      logic [4:0]  l1;
      logic [19:0] c1;
      logic        fl;
      int          n;
      logic [23:0] e;
   } vec_t;

   vec_t vt[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference: a plain bit queue, MSB-first, padded with ones on flush.
   function automatic void model_code(input logic [4:0] len, input logic [19:0] code,
                                      input logic flush);
      for (int i = int'(len) - 1; i >= 0; i--) mq.push_back(code[i]);
      if (flush) while (mq.size() % 8 != 0) mq.push_back(1'b1);
      while (mq.size() >= 8) begin
         logic [7:0] b;
         b = 8'h00;
         for (int j = 0; j < 8; j++) b = {b[6:0], mq.pop_front()};
         exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
         if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
      end
   endfunction

   task automatic send(input logic [4:0] len, input logic [19:0] code, input logic flush);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_len   = len;
      bus.in_code  = code;
      bus.in_flush = flush;
      @(negedge clk);
      while (!bus.in_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      check("send_accepted", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_flush = 1'b0;
   endtask

   task automatic cmp_stream(input string name);
      int k;
      k = 0;
      while (got.size() < exp_q.size() && k < 5000) begin
         @(negedge clk);
         k++;
      end
      repeat (10) @(negedge clk);
      check({name, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: collect accepted bytes, count done pulses, check hold-stability under stall.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_byte", bus.out_byte, hold_byte);
         end
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_byte);
            acc_cyc = cyc;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         hold_q    = bus.out_valid && !bus.out_ready;
         hold_byte = bus.out_byte;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      int n_acc;
      int idx;
      int nfl;
      logic saw_low;
      logic [4:0]  l;
      logic [19:0] c;
      logic        f;

      vt[0] = '{5'd3, 20'h0, 5'd5, 20'h1F, 1'b0, 1, 24'h1F0000};
`ifdef JPEG_BYTE_STUFF_EN
      vt[1] = '{5'd8, 20'hFF, 5'd8, 20'h12, 1'b0, 3, 24'hFF0012};
`else
      vt[1] = '{5'd8, 20'hFF, 5'd8, 20'h12, 1'b0, 2, 24'hFF1200};
`endif
      vt[2] = '{5'd3, 20'h2, 5'd0, 20'h0, 1'b1, 1, 24'h5F0000};
      vt[3] = '{5'd4, 20'hA, 5'd4, 20'h5, 1'b0, 1, 24'hA50000};
`ifdef JPEG_BYTE_STUFF_EN
      vt[4] = '{5'd12, 20'hFFF, 5'd4, 20'h0, 1'b0, 3, 24'hFF00F0};
`else
      vt[4] = '{5'd12, 20'hFFF, 5'd4, 20'h0, 1'b0, 2, 24'hFFF000};
`endif
      vt[5] = '{5'd5, 20'h15, 5'd0, 20'h0, 1'b1, 1, 24'hAF0000};
      vt[6] = '{5'd20, 20'hABCDE, 5'd4, 20'h0, 1'b0, 3, 24'hABCDE0};
`ifdef JPEG_BYTE_STUFF_EN
      vt[7] = '{5'd7, 20'h7F, 5'd0, 20'h0, 1'b1, 2, 24'hFF0000};
`else
      vt[7] = '{5'd7, 20'h7F, 5'd0, 20'h0, 1'b1, 1, 24'hFF0000};
`endif
      vt[8] = '{5'd2, 20'hFFFFD, 5'd6, 20'h2A, 1'b0, 1, 24'h6A0000};

      bus.in_valid  = 1'b0;
      bus.in_len    = 5'd0;
      bus.in_code   = 20'h0;
      bus.in_flush  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_done", bus.done, 0);
      check("rst_out_byte", bus.out_byte, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;

      // Directed table
      for (int t = 0; t < 9; t++) begin
         d0 = done_cnt;
         send(vt[t].l0, vt[t].c0, 1'b0);
         send(vt[t].l1, vt[t].c1, vt[t].fl);
         for (int j = 0; j < vt[t].n; j++) exp_q.push_back(vt[t].e[23 - 8*j -: 8]);
         cmp_stream($sformatf("vec%0d", t));
         check($sformatf("vec%0d_done", t), done_cnt - d0, {31'b0, vt[t].fl});
      end

      // done must wait for the padded byte to be taken by the consumer
      d0 = done_cnt;
      bus.out_ready = 1'b0;
      send(5'd3, 20'hFFFFA, 1'b1);
      repeat (6) @(negedge clk);
      check("flush_done_held", done_cnt - d0, 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      exp_q.push_back(8'h5F);
      cmp_stream("flush5f");
      check("flush5f_done_once", done_cnt - d0, 1);
      check("flush5f_done_after_byte", done_cyc > acc_cyc, 1);

      // Backpressure with 20-bit codes streaming
      bus.out_ready = 1'b0;
      n_acc   = 0;
      saw_low = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_len   = 5'd20;
      bus.in_code  = 20'hABCDE;
      bus.in_flush = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.in_ready) n_acc++;
         else saw_low = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_accepts", n_acc, 2);
      check("bp_in_ready_dropped", saw_low, 1);
      check("bp_no_bytes_while_stalled", got.size(), 0);
      bus.out_ready = 1'b1;
      d0 = done_cnt;
      send(5'd0, 20'h0, 1'b1);
      exp_q.push_back(8'hAB);
      exp_q.push_back(8'hCD);
      exp_q.push_back(8'hEA);
      exp_q.push_back(8'hBC);
      exp_q.push_back(8'hDE);
      cmp_stream("bp");
      check("bp_done", done_cnt - d0, 1);

      // Reset mid-segment: fill=13 with a byte held in the output register
      bus.out_ready = 1'b0;
      send(5'd20, 20'hABCDE, 1'b0);
      send(5'd1, 20'h1, 1'b0);
      check("pre_rst_out_valid", bus.out_valid, 1);
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      got.delete();
      mq.delete();
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(5'd8, 20'h3C, 1'b0);
      exp_q.push_back(8'h3C);
      cmp_stream("after_rst");

      // Flush with nothing buffered: no bytes, prompt done
      d0 = done_cnt;
      send(5'd0, 20'h0, 1'b1);
      idx = 99;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done_cnt > d0 && idx == 99) idx = k;
      end
      check("empty_flush_done_latency", idx <= 2, 1);
      check("empty_flush_done_once", done_cnt - d0, 1);
      check("empty_flush_no_bytes", got.size(), 0);
      @(posedge clk);
      #1;

      // Random codes, random consumer stalls, compared with the bit-queue model
      rand_rdy = 1'b1;
      nfl = 0;
      d0 = done_cnt;
      for (int i = 0; i < 400; i++) begin
         l = 5'($urandom_range(0, 20));
         c = ($urandom_range(0, 1) != 0) ? 20'hFFFFF : 20'($urandom);
         f = ($urandom_range(0, 15) == 0) || (i == 399);
         send(l, c, f);
         model_code(l, c, f);
         if (f) nfl++;
      end
      rand_rdy = 1'b0;
      bus.out_ready = 1'b1;
      cmp_stream("random");
      check("random_done_count", done_cnt - d0, nfl);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
